// File: rtl/ant_batch_draw.sv
// Walks every ant through LOAD x, LOAD y, optional ERASE of the old pixel, then DRAW, using the datapath start/finished handshake.
// Each op takes ISSUE + HOLD + WAIT(>=1) cycles; the pass stalls in WAIT until finished_dp, and finished is low while busy.
module ant_batch_draw #(
  parameter int NUM_ANTS = 8,
  parameter int ADDR_W   = 16,
  parameter int INSTR_W  = 32,
  parameter int RESULT_W = 32,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int CNT_W    = $clog2(NUM_ANTS + 1)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  output logic                finished,
  input  logic                mode,
  input  logic [2:0]          colour,
  input  logic [2:0]          bg_colour,
  input  logic [ADDR_W-1:0]   x_base,
  input  logic [ADDR_W-1:0]   y_base,
  input  logic                clear_history,
  output logic [CNT_W-1:0]    ants_drawn,
  output logic                start_dp,
  output logic [INSTR_W-1:0]  instruction_dp,
  input  logic                finished_dp,
  input  logic [RESULT_W-1:0] result_dp
);

  localparam int IDX_W = (NUM_ANTS > 1) ? $clog2(NUM_ANTS) : 1;
  localparam int XY_W  = X_W + Y_W;
  localparam int LPAD  = INSTR_W - 4 - ADDR_W;
  localparam int DPAD  = INSTR_W - 8 - XY_W;
  localparam logic [RESULT_W-1:0] LP_SW   = RESULT_W'(SCREEN_W);
  localparam logic [RESULT_W-1:0] LP_SH   = RESULT_W'(SCREEN_H);
  localparam logic [IDX_W-1:0]    LP_LAST = IDX_W'(NUM_ANTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_WAIT} state_t;
  typedef enum logic [1:0] {P_LOAD_X, P_LOAD_Y, P_ERASE, P_DRAW} step_t;

  state_t              r_state, w_state_nxt;
  step_t               r_step, w_step_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic                r_mode;
  logic [2:0]          r_colour, r_bg;
  logic [ADDR_W-1:0]   r_xbase, r_ybase;
  logic [RESULT_W-1:0] r_x_raw;
  logic [Y_W-1:0]      r_y;
  logic                r_inb;
  logic [CNT_W-1:0]    r_cnt, r_ants_drawn;
  logic [XY_W-1:0]     r_prev [NUM_ANTS];
  logic [NUM_ANTS-1:0] r_prev_valid;
  logic [INSTR_W-1:0]  r_instr, w_instr_nxt;
  logic                w_issue, w_done, w_end_ant, w_last;
  logic [Y_W-1:0]      w_y_cur;
  logic                w_inb_cur, w_need_erase;
  logic [XY_W-1:0]     w_xy_cur;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [ADDR_W-1:0]   w_addr;

  function automatic logic [INSTR_W-1:0] f_load(input logic [ADDR_W-1:0] a);
    return {4'd2, {LPAD{1'b0}}, a};
  endfunction

  function automatic logic [INSTR_W-1:0] f_draw(input logic [2:0] c, input logic [XY_W-1:0] xy);
    return {4'd1, {DPAD{1'b0}}, 1'b1, c, xy};
  endfunction

  // During LOAD_Y completion the y word is still on result_dp, not yet registered.
  assign w_y_cur      = (r_step == P_LOAD_Y) ? result_dp[Y_W-1:0] : r_y;
  assign w_inb_cur    = (r_step == P_LOAD_Y) ? ((r_x_raw < LP_SW) && (result_dp < LP_SH)) : r_inb;
  assign w_xy_cur     = {w_y_cur, r_x_raw[X_W-1:0]};
  assign w_need_erase = r_mode && r_prev_valid[r_idx] && (w_xy_cur != r_prev[r_idx]);
  assign w_cnt_nxt    = r_cnt + ((r_step == P_DRAW) ? CNT_W'(1) : CNT_W'(0));

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_idx_nxt   = r_idx;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    w_end_ant   = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_step_nxt = P_LOAD_X;
        w_idx_nxt  = '0;
        w_issue    = 1'b1;
      end
      S_ISSUE: w_state_nxt = S_HOLD;
      S_HOLD:  w_state_nxt = S_WAIT;
      default: if (finished_dp) begin
        w_done = 1'b1;
        case (r_step)
          P_LOAD_X: begin w_step_nxt = P_LOAD_Y; w_issue = 1'b1; end
          P_LOAD_Y: begin
            if (w_need_erase)   begin w_step_nxt = P_ERASE; w_issue = 1'b1; end
            else if (w_inb_cur) begin w_step_nxt = P_DRAW;  w_issue = 1'b1; end
            else                w_end_ant = 1'b1;
          end
          P_ERASE: begin
            if (r_inb) begin w_step_nxt = P_DRAW; w_issue = 1'b1; end
            else       w_end_ant = 1'b1;
          end
          default: w_end_ant = 1'b1;
        endcase
        if (w_end_ant) begin
          if (r_idx == LP_LAST) begin
            w_last      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt  = r_idx + IDX_W'(1);
            w_step_nxt = P_LOAD_X;
            w_issue    = 1'b1;
          end
        end
      end
    endcase
    if (w_issue) w_state_nxt = S_ISSUE;
  end

  // Instruction for the op about to be issued; bases come straight from the ports on the start cycle.
  always_comb begin
    w_addr      = '0;
    w_instr_nxt = '0;
    case (w_step_nxt)
      P_LOAD_X: begin
        w_addr      = ((r_state == S_IDLE) ? x_base : r_xbase) + ADDR_W'(w_idx_nxt);
        w_instr_nxt = f_load(w_addr);
      end
      P_LOAD_Y: begin
        w_addr      = r_ybase + ADDR_W'(w_idx_nxt);
        w_instr_nxt = f_load(w_addr);
      end
      P_ERASE: w_instr_nxt = f_draw(r_bg, r_prev[w_idx_nxt]);
      default: w_instr_nxt = f_draw(r_colour, w_xy_cur);
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_step  <= P_LOAD_X;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mode       <= 1'b0;
      r_colour     <= '0;
      r_bg         <= '0;
      r_xbase      <= '0;
      r_ybase      <= '0;
      r_x_raw      <= '0;
      r_y          <= '0;
      r_inb        <= 1'b0;
      r_cnt        <= '0;
      r_ants_drawn <= '0;
      r_prev_valid <= '0;
      r_instr      <= '0;
      for (int i = 0; i < NUM_ANTS; i++) r_prev[i] <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (clear_history) r_prev_valid <= '0;
        if (start) begin
          r_mode   <= mode;
          r_colour <= colour;
          r_bg     <= bg_colour;
          r_xbase  <= x_base;
          r_ybase  <= y_base;
          r_cnt    <= '0;
        end
      end else if (w_done) begin
        case (r_step)
          P_LOAD_X: r_x_raw <= result_dp;
          P_LOAD_Y: begin
            r_y   <= result_dp[Y_W-1:0];
            r_inb <= w_inb_cur;
          end
          default: ;
        endcase
        r_cnt <= w_cnt_nxt;
        if (w_end_ant) begin
          r_prev[r_idx]       <= w_xy_cur;
          r_prev_valid[r_idx] <= w_inb_cur;
          if (w_last) r_ants_drawn <= w_cnt_nxt;
        end
      end
      if (w_issue) r_instr <= w_instr_nxt;
    end
  end

  assign finished       = (r_state == S_IDLE);
  assign start_dp       = (r_state == S_ISSUE) || (r_state == S_HOLD);
  assign instruction_dp = r_instr;
  assign ants_drawn     = r_ants_drawn;

endmodule
